// File: rtl/gpr_sb.sv
// ---------------------------------------------------------------------------
// gpr_sb : general-purpose register file with a pending-write scoreboard.
//
// Two combinational read ports and one clocked write port. Each register
// has a busy bit, set when decode issues an instruction that will write it
// and cleared when that write comes back. Reads of a busy register raise
// stall. An optional same-cycle bypass forwards writeback data to readers.
// Register 0 always reads 0 and is never marked busy.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   RegWr     in   writeback enable
//   rw        in   writeback register index
//   busW      in   writeback data
//   ra, rb    in   read port indices
//   busA      out  read data A
//   busB      out  read data B
//   Data_in   out  store data (same value as busB)
//   iss_vld   in   decode issues an instruction that writes iss_rd
//   iss_rd    in   destination of the issuing instruction
//   stall     out  source hazard on ra or rb
//   busy      out  scoreboard vector, bit 0 always 0
//   pend_cnt  out  number of set busy bits
// ---------------------------------------------------------------------------
module gpr_sb #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RegWr,
   input  logic [AW-1:0]        rw,
   input  logic [DW-1:0]        busW,
   input  logic [AW-1:0]        ra,
   input  logic [AW-1:0]        rb,
   output logic [DW-1:0]        busA,
   output logic [DW-1:0]        busB,
   output logic [DW-1:0]        Data_in,
   input  logic                 iss_vld,
   input  logic [AW-1:0]        iss_rd,
   output logic                 stall,
   output logic [(1<<AW)-1:0]   busy,
   output logic [AW:0]          pend_cnt
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0]    r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic [AW:0]      r_pend_cnt;

   logic             w_wr_en;
   logic             w_set;
   logic             w_clr;
   logic             w_inc;
   logic             w_dec;
   logic [DEPTH-1:0] w_busy_nxt;
   logic             w_fwd_a;
   logic             w_fwd_b;
   logic             w_haz_a;
   logic             w_haz_b;
   logic [DW-1:0]    w_rd_a;
   logic [DW-1:0]    w_rd_b;

   assign w_wr_en = RegWr && (rw != '0);
   assign w_set   = iss_vld && (iss_rd != '0);
   assign w_clr   = w_wr_en;

   // ---------------- register array ----------------
   // Entry 0 is reset like the others but never written, so it stays 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[rw] <= busW;
      end
   end

   // ---------------- read ports ----------------
   assign w_fwd_a = BYPASS && w_wr_en && (rw == ra);
   assign w_fwd_b = BYPASS && w_wr_en && (rw == rb);

   always_comb begin
      w_rd_a = '0;
      if (ra != '0) begin
         w_rd_a = w_fwd_a ? busW : r_regs[ra];
      end
   end

   always_comb begin
      w_rd_b = '0;
      if (rb != '0) begin
         w_rd_b = w_fwd_b ? busW : r_regs[rb];
      end
   end

   assign busA    = w_rd_a;
   assign busB    = w_rd_b;
   assign Data_in = w_rd_b;

   // ---------------- scoreboard ----------------
   // Set is applied after clear so a new producer issued in the writeback
   // cycle of the old one keeps the register busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_clr) begin
         w_busy_nxt[rw] = 1'b0;
      end
      if (w_set) begin
         w_busy_nxt[iss_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Count tracks the popcount incrementally: a set only adds if the bit
   // was clear, a clear only subtracts if the bit was set and not re-set.
   assign w_inc = w_set && !r_busy[iss_rd];
   assign w_dec = w_clr && r_busy[rw] && !(w_set && (iss_rd == rw));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         r_pend_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_pend_cnt <= r_pend_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
      end
   end

   assign busy     = r_busy;
   assign pend_cnt = r_pend_cnt;

   // ---------------- hazard detect ----------------
   // With bypass the writeback cycle itself resolves the hazard; without
   // it the reader must wait until the value is in the array.
   assign w_haz_a = (ra != '0) && r_busy[ra] && !w_fwd_a;
   assign w_haz_b = (rb != '0) && r_busy[rb] && !w_fwd_b;
   assign stall   = w_haz_a || w_haz_b;

endmodule

// File: tb/tb_gpr_sb.sv
module tb_gpr_sb;

   localparam int DW = 32;
   localparam int AW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            RegWr;
   logic [AW-1:0]   rw;
   logic [DW-1:0]   busW;
   logic [AW-1:0]   ra;
   logic [AW-1:0]   rb;
   logic [DW-1:0]   busA;
   logic [DW-1:0]   busB;
   logic [DW-1:0]   Data_in;
   logic            iss_vld;
   logic [AW-1:0]   iss_rd;
   logic            stall;
   logic [31:0]     busy;
   logic [AW:0]     pend_cnt;

   gpr_sb #(.DW(DW), .AW(AW), .BYPASS(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .RegWr    (RegWr),
      .rw       (rw),
      .busW     (busW),
      .ra       (ra),
      .rb       (rb),
      .busA     (busA),
      .busB     (busB),
      .Data_in  (Data_in),
      .iss_vld  (iss_vld),
      .iss_rd   (iss_rd),
      .stall    (stall),
      .busy     (busy),
      .pend_cnt (pend_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q [$];
   string       tag_q [$];

   int          m_cnt;
   logic [31:0] m_busy;

   task automatic expect_val(input string tag, input logic [63:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check(input logic [63:0] obs);
      logic [63:0] e;
      string       t;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_checks++;
         assert (obs === e) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", t, obs, e);
            $error("check %s", t);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegWr   = 1'b0;
      rw      = '0;
      busW    = '0;
      iss_vld = 1'b0;
      iss_rd  = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      ra = '0;
      rb = '0;
      #2;
      expect_val("reset_busy", 64'd0);      check(64'(busy));
      expect_val("reset_cnt", 64'd0);       check(64'(pend_cnt));
      tick();
      rst = 1'b0;
      tick();

      // write r5 and issue r9, then reset between edges
      RegWr = 1'b1; rw = 5; busW = 32'hDEADBEEF; iss_vld = 1'b1; iss_rd = 9;
      tick();
      idle(); ra = 5;
      #2;
      expect_val("pre_rst_busA", 64'hDEADBEEF); check(64'(busA));
      expect_val("pre_rst_cnt", 64'd1);         check(64'(pend_cnt));
      rst = 1'b1;
      #1;
      expect_val("rst_busA", 64'd0);  check(64'(busA));
      expect_val("rst_busy", 64'd0);  check(64'(busy));
      expect_val("rst_cnt", 64'd0);   check(64'(pend_cnt));
      #1;
      rst = 1'b0;
      tick();

      // r0 protection
      RegWr = 1'b1; rw = 0; busW = 32'hFFFFFFFF; iss_vld = 1'b1; iss_rd = 0; ra = 0;
      #2;
      expect_val("r0_bypass", 64'd0); check(64'(busA));
      tick();
      idle();
      #2;
      expect_val("r0_busA", 64'd0);   check(64'(busA));
      expect_val("r0_busy", 64'd0);   check(64'(busy));
      expect_val("r0_cnt", 64'd0);    check(64'(pend_cnt));

      // bypass
      RegWr = 1'b1; rw = 7; busW = 32'h11;
      tick();
      RegWr = 1'b1; rw = 7; busW = 32'h22; ra = 7; rb = 7;
      #2;
      expect_val("byp_busA", 64'h22);    check(64'(busA));
      expect_val("byp_busB", 64'h22);    check(64'(busB));
      expect_val("byp_Data_in", 64'h22); check(64'(Data_in));
      tick();
      idle();
      #2;
      expect_val("byp_after", 64'h22);   check(64'(busA));
      ra = 0; rb = 0;

      // hazard on r3
      iss_vld = 1'b1; iss_rd = 3;
      tick();
      idle(); ra = 3;
      #2;
      expect_val("haz_stall_a", 64'd1); check(64'(stall));
      expect_val("haz_cnt", 64'd1);     check(64'(pend_cnt));
      ra = 0; rb = 3;
      #1;
      expect_val("haz_stall_b", 64'd1); check(64'(stall));
      rb = 0; ra = 3;
      tick();
      RegWr = 1'b1; rw = 3; busW = 32'h33;
      #2;
      expect_val("haz_wb_stall", 64'd0); check(64'(stall));
      expect_val("haz_wb_busA", 64'h33); check(64'(busA));
      tick();
      idle();
      #2;
      expect_val("haz_busy3", 64'd0); check(64'(busy[3]));
      expect_val("haz_cnt0", 64'd0);  check(64'(pend_cnt));
      expect_val("haz_clear", 64'd0); check(64'(stall));
      ra = 0;

      // simultaneous set and clear
      iss_vld = 1'b1; iss_rd = 4;
      tick();
      idle();
      #2;
      expect_val("sc_busy4", 64'd1); check(64'(busy[4]));
      expect_val("sc_cnt1", 64'd1);  check(64'(pend_cnt));
      iss_vld = 1'b1; iss_rd = 4; RegWr = 1'b1; rw = 4; busW = 32'h44;
      tick();
      idle();
      #2;
      expect_val("sc_same_busy4", 64'd1); check(64'(busy[4]));
      expect_val("sc_same_cnt", 64'd1);   check(64'(pend_cnt));
      iss_vld = 1'b1; iss_rd = 6; RegWr = 1'b1; rw = 4; busW = 32'h45;
      tick();
      idle();
      #2;
      expect_val("sc_diff_busy", 64'h40); check(64'(busy));
      expect_val("sc_diff_cnt", 64'd1);   check(64'(pend_cnt));
      RegWr = 1'b1; rw = 10; busW = 32'hA;
      tick();
      idle();
      #2;
      expect_val("clr_idle_cnt", 64'd1); check(64'(pend_cnt));
      RegWr = 1'b1; rw = 6; busW = 32'h6;
      tick();
      idle();
      #2;
      expect_val("clr6_cnt", 64'd0); check(64'(pend_cnt));

      // fill r1..r31 then drain
      m_cnt  = 0;
      m_busy = '0;
      for (int i = 1; i < 32; i++) begin
         iss_vld = 1'b1; iss_rd = AW'(i);
         m_cnt++;
         m_busy[i] = 1'b1;
         expect_val($sformatf("fill_cnt_%0d", i), 64'(m_cnt));
         tick();
         check(64'(pend_cnt));
      end
      idle();
      #2;
      expect_val("fill_full_cnt", 64'd31);   check(64'(pend_cnt));
      expect_val("fill_busy", 64'(m_busy));  check(64'(busy));
      for (int i = 1; i < 32; i++) begin
         RegWr = 1'b1; rw = AW'(i); busW = 32'(i * 3);
         m_cnt--;
         m_busy[i] = 1'b0;
         expect_val($sformatf("drain_cnt_%0d", i), 64'(m_cnt));
         tick();
         check(64'(pend_cnt));
      end
      idle();
      ra = 31;
      #2;
      expect_val("drain_busy", 64'(m_busy)); check(64'(busy));
      expect_val("drain_r31", 64'd93);       check(64'(busA));

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpr_sb.md
Name: gpr_sb

Overview:
- Parametrised general-purpose register file with two asynchronous read ports and one synchronous write port.
- Adds a per-register pending-write scoreboard, same-cycle write-to-read bypass, a hazard stall output and an outstanding-write counter.
- Sits between decode and writeback in the pipelined CPU datapath.
- Register 0 reads as zero and is never marked busy.

Parameters:
- DW, 32, data width of each register and of the buses.
- AW, 5, address width; depth is 2**AW registers.
- BYPASS, 1, when 1 the write data is forwarded combinationally to matching read ports in the same cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- RegWr  in  1  writeback enable.
- rw  in  AW  writeback register index.
- busW  in  DW  writeback data.
- ra  in  AW  read port A index.
- rb  in  AW  read port B index.
- busA  out  DW  read data A.
- busB  out  DW  read data B.
- Data_in  out  DW  store data; always equal to busB.
- iss_vld  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  AW  destination of the issuing instruction.
- stall  out  1  source hazard on ra or rb.
- busy  out  2**AW  scoreboard vector; bit 0 is always 0.
- pend_cnt  out  AW+1  number of set busy bits.

Behaviour:
- Reset (async, rst=1):
  - All registers are cleared to 0.
  - busy and pend_cnt are cleared to 0.
  - Outputs settle to 0 without a clock edge.
  - Reset asserted mid-operation discards all pending writes; a write coinciding with reset is lost.
- Write:
  - On posedge clk with RegWr=1 and rw!=0, regs[rw] <= busW.
  - rw=0 is ignored; regs[0] stays 0 permanently.
- Read:
  - busA = (ra==0) ? 0 : regs[ra].
  - When BYPASS=1, RegWr=1, rw==ra and ra!=0, busA = busW.
  - busB follows the same rules using rb.
  - Read latency is 0 cycles (combinational).
- Scoreboard (clocked update):
  - Set: iss_vld=1 and iss_rd!=0 sets busy[iss_rd].
  - Clear: RegWr=1 and rw!=0 clears busy[rw].
  - Set and clear on the same index in the same cycle: set wins, because the new producer supersedes the old one.
  - Sets and clears on different indices both take effect.
  - Re-setting an already-busy bit leaves it busy; there is no counting per register.
  - Clearing a non-busy register is legal and leaves the bit 0.
- pend_cnt:
  - Registered; always equals the popcount of busy.
  - Changes by -1, 0 or +1 per cycle.
  - Maximum value is 2**AW - 1.
- stall (combinational):
  - stall = (ra!=0 && busy[ra] && !(RegWr && rw==ra)) || (the same term for rb).
  - With BYPASS=0 the writeback exemption is removed; stall holds until the cycle after writeback.
- iss_vld is not gated by stall inside the block; decode must hold issue while stall=1.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst between clock edges -> busA for ra=5 reads 0 immediately; busy=0 and pend_cnt=0 before the next edge.
- r0 protection: RegWr=1, rw=0, busW=0xFFFFFFFF, iss_vld=1, iss_rd=0 -> busA for ra=0 stays 0; busy[0]=0; pend_cnt unchanged.
- Bypass: r7=0x11; in the same cycle RegWr=1, rw=7, busW=0x22 with ra=7 and rb=7 -> busA=busB=Data_in=0x22 before the edge; after the edge regs[7]=0x22.
- Hazard: issue iss_rd=3, then hold ra=3 -> stall=1 and pend_cnt=1; on the writeback cycle RegWr=1, rw=3 -> stall=0 (BYPASS=1); next cycle busy[3]=0, pend_cnt=0.
- Simultaneous set and clear: busy[4]=1, then iss_vld=1, iss_rd=4 with RegWr=1, rw=4 -> busy[4] remains 1 and pend_cnt unchanged; a different-index case (set 6, clear 4) -> pend_cnt unchanged, busy[6]=1, busy[4]=0.
- Fill: issue r1 through r31 on consecutive cycles -> pend_cnt reaches 31 with no wrap; write back all 31 -> pend_cnt returns to 0.
